// File: rtl/alu_pkg.sv
// Opcodes, legality check and FSM state encoding shared by the ALU command
// issuer and anything else that drives the 26-bit registered ALU.
package alu_pkg;

  localparam int WIDTH = 26;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_NOP   = 4'b1000;
  localparam logic [3:0] OP_PASSA = 4'b1101;
  localparam logic [3:0] OP_PASSB = 4'b1110;
  localparam logic [3:0] OP_PASS0 = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    CAP1  = 3'd2,
    EXEC2 = 3'd3,
    CAP2  = 3'd4,
    RESP  = 3'd5
  } state_t;

  // 1000..1100 are reserved; NOP is reserved for the issuer's own use.
  function automatic logic is_legal_op(input logic [3:0] op);
    return !((op >= 4'b1000) && (op <= 4'b1100));
  endfunction

  // Only add/sub report a meaningful carry out of the ALU.
  function automatic logic has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues one or two (chained) operations to an external registered ALU and
// returns the final result and carry over a valid/ready response channel.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_chain,
  input  logic [3:0]       req_op2,
  input  logic [WIDTH-1:0] req_b2,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err
);

  state_t           state_reg, state_next;
  logic [3:0]       opcode_next;
  logic [WIDTH-1:0] in1_next, in2_next;
  logic             rsp_valid_next, rsp_carry_next, rsp_err_next;
  logic [WIDTH-1:0] rsp_data_next;
  logic             chain_reg, chain_next;
  logic [3:0]       op1_reg, op1_next, op2_reg, op2_next;
  logic [WIDTH-1:0] b2_reg, b2_next;

  assign req_ready = (state_reg == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      alu_opcode <= OP_NOP;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      chain_reg  <= 1'b0;
      op1_reg    <= OP_NOP;
      op2_reg    <= OP_NOP;
      b2_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      alu_opcode <= opcode_next;
      alu_in1    <= in1_next;
      alu_in2    <= in2_next;
      rsp_valid  <= rsp_valid_next;
      rsp_data   <= rsp_data_next;
      rsp_carry  <= rsp_carry_next;
      rsp_err    <= rsp_err_next;
      chain_reg  <= chain_next;
      op1_reg    <= op1_next;
      op2_reg    <= op2_next;
      b2_reg     <= b2_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    opcode_next    = alu_opcode;
    in1_next       = alu_in1;
    in2_next       = alu_in2;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    rsp_carry_next = rsp_carry;
    rsp_err_next   = rsp_err;
    chain_next     = chain_reg;
    op1_next       = op1_reg;
    op2_next       = op2_reg;
    b2_next        = b2_reg;

    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          // op2 only matters for legality when a second step will run
          if (is_legal_op(req_op1) && (!req_chain || is_legal_op(req_op2))) begin
            opcode_next = req_op1;
            in1_next    = req_a;
            in2_next    = req_b;
            chain_next  = req_chain;
            op1_next    = req_op1;
            op2_next    = req_op2;
            b2_next     = req_b2;
            state_next  = EXEC1;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_carry_next = 1'b0;
            rsp_err_next   = 1'b1;
            state_next     = RESP;
          end
        end
      end
      EXEC1: begin
        opcode_next = OP_NOP;
        state_next  = CAP1;
      end
      CAP1: begin
        if (chain_reg) begin
          opcode_next = op2_reg;
          in1_next    = alu_out;
          in2_next    = b2_reg;
          state_next  = EXEC2;
        end else begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = alu_out;
          rsp_carry_next = alu_carry & has_carry(op1_reg);
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end
      end
      EXEC2: begin
        opcode_next = OP_NOP;
        state_next  = CAP2;
      end
      CAP2: begin
        rsp_valid_next = 1'b1;
        rsp_data_next  = alu_out;
        rsp_carry_next = alu_carry & has_carry(op2_reg);
        rsp_err_next   = 1'b0;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small registered ALU model driven
// by the issuer's alu_* outputs.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int W = 26;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_chain;
  logic [3:0]   req_op1, req_op2;
  logic [W-1:0] req_a, req_b, req_b2;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic         alu_carry;
  logic         rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [W-1:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_a(req_a), .req_b(req_b),
    .req_chain(req_chain), .req_op2(req_op2), .req_b2(req_b2),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // Registered ALU model: result appears one edge after inputs are sampled.
  function automatic logic [W:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = '0;
    case (op)
      OP_ADD:   return {1'b0, a} + {1'b0, b};
      OP_SUB:   return {1'b0, a} - {1'b0, b};
      OP_MUL: begin
        p = a * b;
        return {|p[2*W-1:W], p[W-1:0]};
      end
      OP_AND:   return {1'b0, a & b};
      OP_OR:    return {1'b0, a | b};
      OP_NOT:   return {1'b0, ~a};
      OP_SHL:   return {1'b0, a << b[4:0]};
      OP_SRA:   return {1'b0, W'($signed(a) >>> b[4:0])};
      OP_PASSA: return {1'b0, a};
      OP_PASSB: return {1'b0, b};
      default:  return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) {alu_carry, alu_out} <= '0;
    else       {alu_carry, alu_out} <= alu_f(alu_opcode, alu_in1, alu_in2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op1, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic chain, input logic [3:0] op2, input logic [W-1:0] b2);
    req_op1 = op1; req_a = a; req_b = b;
    req_chain = chain; req_op2 = op2; req_b2 = b2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op1 = '0; req_op2 = '0; req_a = '0; req_b = '0; req_b2 = '0; req_chain = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_opcode", 32'(alu_opcode), 32'h8);
    check("rst_in1", 32'(alu_in1), 0);
    check("rst_rsp", {rsp_valid, rsp_carry, rsp_err, rsp_data}, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("idle_ready", 32'(req_ready), 1);
    $display("txn reset: done");

    // single add with carry out
    issue(OP_ADD, 26'h3FFFFFF, 26'h1, 1'b0, OP_NOP, '0);
    check("add_e0_opcode", 32'(alu_opcode), 32'h0);
    check("add_e0_in1", 32'(alu_in1), 32'h3FFFFFF);
    check("add_e0_in2", 32'(alu_in2), 32'h1);
    check("add_e0_ready", 32'(req_ready), 0);
    tick();
    check("add_e1_opcode", 32'(alu_opcode), 32'h8);
    check("add_e1_valid", 32'(rsp_valid), 0);
    tick();
    check("add_e2_valid", 32'(rsp_valid), 1);
    check("add_data", 32'(rsp_data), 0);
    check("add_carry", 32'(rsp_carry), 1);
    check("add_err", 32'(rsp_err), 0);
    // back-pressure
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {req_ready, rsp_valid, rsp_carry, rsp_err, rsp_data}, {1'b0, 1'b1, 1'b1, 1'b0, 26'h0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release_valid", 32'(rsp_valid), 0);
    check("bp_release_ready", 32'(req_ready), 1);
    $display("txn add: data=%0h carry=%0b", rsp_data, rsp_carry);

    // chained mul then sra: (6*7)>>>1 = 21
    issue(OP_MUL, 26'd6, 26'd7, 1'b1, OP_SRA, 26'd1);
    check("ch_e0_opcode", 32'(alu_opcode), 32'h2);
    tick();
    check("ch_e1_opcode", 32'(alu_opcode), 32'h8);
    tick();
    check("ch_e2_opcode", 32'(alu_opcode), 32'h7);
    check("ch_e2_in1", 32'(alu_in1), 32'd42);
    check("ch_e2_in2", 32'(alu_in2), 32'd1);
    check("ch_e2_valid", 32'(rsp_valid), 0);
    tick();
    check("ch_e3_opcode", 32'(alu_opcode), 32'h8);
    check("ch_e3_valid", 32'(rsp_valid), 0);
    tick();
    check("ch_e4_valid", 32'(rsp_valid), 1);
    check("ch_data", 32'(rsp_data), 32'd21);
    check("ch_carry", 32'(rsp_carry), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("ch_done", 32'(rsp_valid), 0);
    $display("txn chain: data=%0d carry=%0b", rsp_data, rsp_carry);

    // mul overflow: ALU carry must be masked, product truncated
    issue(OP_MUL, 26'h2000000, 26'd2, 1'b0, OP_NOP, '0);
    tick(); tick();
    check("mul_valid", 32'(rsp_valid), 1);
    check("mul_data", 32'(rsp_data), 0);
    check("mul_carry_masked", 32'(rsp_carry), 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn mul: data=%0h carry=%0b", rsp_data, rsp_carry);

    // sub with borrow
    issue(OP_SUB, 26'd0, 26'd1, 1'b0, OP_NOP, '0);
    tick(); tick();
    check("sub_data", 32'(rsp_data), 32'h3FFFFFF);
    check("sub_carry", 32'(rsp_carry), 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn sub: data=%0h carry=%0b", rsp_data, rsp_carry);

    // illegal op1
    issue(4'b1010, 26'd5, 26'd5, 1'b0, OP_NOP, '0);
    check("ill_valid", 32'(rsp_valid), 1);
    check("ill_err", 32'(rsp_err), 1);
    check("ill_data", 32'(rsp_data), 0);
    check("ill_carry", 32'(rsp_carry), 0);
    check("ill_opcode", 32'(alu_opcode), 32'h8);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    check("ill_done_valid", 32'(rsp_valid), 0);
    check("ill_done_ready", 32'(req_ready), 1);
    check("ill_done_opcode", 32'(alu_opcode), 32'h8);
    $display("txn illegal op1: err=%0b", rsp_err);

    // illegal op2 on a chained request
    issue(OP_ADD, 26'd1, 26'd1, 1'b1, 4'b1100, 26'd1);
    check("ill2_err", {rsp_valid, rsp_err}, 2'b11);
    check("ill2_opcode", 32'(alu_opcode), 32'h8);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn illegal op2: err=%0b", rsp_err);

    // illegal op2 ignored when not chained
    issue(OP_ADD, 26'd2, 26'd3, 1'b0, 4'b1001, 26'd1);
    tick(); tick();
    check("nochain_op2_data", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 26'd5});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn unchained op2: data=%0d", rsp_data);

    // reset asserted in CAP1 of a chained mul
    issue(OP_MUL, 26'd6, 26'd7, 1'b1, OP_SRA, 26'd1);
    tick();
    #2 reset = 1'b1;
    #1;
    check("mrst_opcode", 32'(alu_opcode), 32'h8);
    check("mrst_in", {alu_in1, alu_in2}, 0);
    check("mrst_rsp", {rsp_valid, rsp_carry, rsp_err, rsp_data}, 0);
    check("mrst_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_rsp", 32'(rsp_valid), 0);
    end
    issue(OP_ADD, 26'd5, 26'd6, 1'b0, OP_NOP, '0);
    tick(); tick();
    check("post_rst_data", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 26'd11});
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn post-reset add: data=%0d", rsp_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
